// File: rtl/multicycle_controller_if.sv
// Control bundle between a multicycle RISC-V datapath and its controller.
// Instruction fields and the ALU zero flag come from the datapath. Select,
// enable and decode outputs go back to it.
//   master : datapath side (drives op/funct3/funct7b5/Zero, reads controls)
//   slave  : controller side
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       Illegal;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RV32I subset
// (lw, sw, R-type, I-ALU, beq, jal, jalr, lui).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; returns the FSM to FETCH
//   bus   : slave modport of multicycle_controller_if (instruction fields in,
//           datapath controls out)
// Per-state controls are registered together with the state, so they always
// match state_q. PCWrite, ImmSrc, ALUControl (funct path) and Illegal are
// combinational because they depend on live inputs.
module multicycle_controller (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.slave   bus
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecuteR,
        StExecuteI, StAluWb, StBeq, StJal, StJalr, StJalrLink, StLui
    } state_e;

    typedef enum logic [1:0] {AluAdd, AluSub, AluFunct} alu_op_e;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_e    alu_op;
    } ctrl_t;

    // Moore output table: fields not set here stay 0.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        unique case (s)
            StFetch: begin
                c.ir_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            StDecode: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            StMemRead: c.adr_src = 1'b1;
            StMemWrite: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            StMemWb: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            StExecuteR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = AluFunct;
            end
            StExecuteI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = AluFunct;
            end
            StAluWb: c.reg_write = 1'b1;
            StBeq: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = AluSub;
                c.branch    = 1'b1;
            end
            StJal: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            StJalr: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            StJalrLink: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            StLui: begin
                c.result_src = 2'b11;
                c.reg_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   op_supported;
    logic   wr_en;
    logic [2:0] alu_funct;

    always_comb begin
        unique case (bus.op)
            OpLoad, OpStore, OpRType, OpIAlu, OpBranch, OpJal, OpJalr, OpLui:
                op_supported = 1'b1;
            default: op_supported = 1'b0;
        endcase
    end

    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                unique case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIAlu:          state_d = StExecuteI;
                    OpBranch:        state_d = StBeq;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead: state_d = StMemWb;
            StExecuteR, StExecuteI, StJal, StJalrLink: state_d = StAluWb;
            StJalr:    state_d = StJalrLink;
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ctrl_q  <= state_ctrl(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    // funct3 000 is sub only for R-type (op[5]) with funct7b5 set; addi stays add.
    always_comb begin
        unique case (bus.funct3)
            3'b000:  alu_funct = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_funct = 3'b101;
            3'b110:  alu_funct = 3'b011;
            3'b111:  alu_funct = 3'b010;
            default: alu_funct = 3'b000;
        endcase
    end

    always_comb begin
        unique case (ctrl_q.alu_op)
            AluSub:   bus.ALUControl = 3'b001;
            AluFunct: bus.ALUControl = alu_funct;
            default:  bus.ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        unique case (bus.op)
            OpStore:  bus.ImmSrc = 3'b001;
            OpBranch: bus.ImmSrc = 3'b010;
            OpJal:    bus.ImmSrc = 3'b011;
            OpLui:    bus.ImmSrc = 3'b100;
            default:  bus.ImmSrc = 3'b000;
        endcase
    end

    // Architectural write enables are gated while reset is high.
    assign wr_en        = ~reset;
    assign bus.PCWrite  = wr_en & (ctrl_q.pc_update | (ctrl_q.branch & bus.Zero));
    assign bus.IRWrite  = wr_en & ctrl_q.ir_write;
    assign bus.MemWrite = wr_en & ctrl_q.mem_write;
    assign bus.RegWrite = wr_en & ctrl_q.reg_write;
    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.Illegal   = (state_q == StDecode) && !op_supported;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes one
// expected output vector per cycle from an instruction-level model; a monitor
// pops and compares on every falling edge.
module tb_multicycle_controller;

    typedef enum int {
        SFetch, SDecode, SMemAdr, SMemRead, SMemWb, SMemWrite, SExecR, SExecI,
        SAluWb, SBeq, SJal, SJalr, SJalrLink, SLui
    } step_e;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
    //  ALUSrcB, ALUControl, ImmSrc, Illegal}
    typedef logic [17:0] vec_t;

    logic clk = 1'b0;
    logic reset;
    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;
    vec_t  got_vec;
    vec_t  mon_exp;
    string mon_tag;

    assign got_vec = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                      bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                      bus.ImmSrc, bus.Illegal};

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                total++;
                if (got_vec !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got=%b want=%b", mon_tag, got_vec, mon_exp);
                end
            end
        end
    end

    function automatic bit supported(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    endfunction

    // Instruction class -> sequence of steps it walks through.
    function automatic void steps_for(input logic [6:0] op, output step_e s[$]);
        s = {SFetch, SDecode};
        case (op)
            7'b0000011: s = {s, SMemAdr, SMemRead, SMemWb};
            7'b0100011: s = {s, SMemAdr, SMemWrite};
            7'b0110011: s = {s, SExecR, SAluWb};
            7'b0010011: s = {s, SExecI, SAluWb};
            7'b1100011: s = {s, SBeq};
            7'b1101111: s = {s, SJal, SAluWb};
            7'b1100111: s = {s, SJalr, SJalrLink, SAluWb};
            7'b0110111: s = {s, SLui};
            default: ;
        endcase
    endfunction

    function automatic vec_t model(input step_e s, input logic [6:0] op,
                                   input logic [2:0] f3, input logic f7,
                                   input logic z, input logic rst);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, a, b;
        logic [2:0] alu, imm, fn;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; a = 0; b = 0; alu = 3'b000;
        case (op)
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b1101111: imm = 3'b011;
            7'b0110111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        case (f3)
            3'b000:  fn = (op[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  fn = 3'b101;
            3'b110:  fn = 3'b011;
            3'b111:  fn = 3'b010;
            default: fn = 3'b000;
        endcase
        case (s)
            SFetch:    begin irw = 1; b = 2; rs = 2; pcw = 1; end
            SDecode:   begin a = 1; b = 1; ill = !supported(op); end
            SMemAdr:   begin a = 2; b = 1; end
            SMemRead:  adr = 1;
            SMemWrite: begin adr = 1; mw = 1; end
            SMemWb:    begin rs = 1; rw = 1; end
            SExecR:    begin a = 2; alu = fn; end
            SExecI:    begin a = 2; b = 1; alu = fn; end
            SAluWb:    rw = 1;
            SBeq:      begin a = 2; alu = 3'b001; pcw = z; end
            SJal:      begin a = 1; b = 2; pcw = 1; end
            SJalr:     begin a = 2; b = 1; rs = 2; pcw = 1; end
            SJalrLink: begin a = 1; b = 2; end
            SLui:      begin rs = 3; rw = 1; end
            default: ;
        endcase
        if (rst) begin
            pcw = 0; irw = 0; mw = 0; rw = 0;
        end
        return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
    endfunction

    // Entered at posedge+1 with the DUT in FETCH. rst_at >= 0 asserts reset
    // during that step, which aborts the instruction.
    task automatic run_instr(input string name, input logic [6:0] op,
                             input logic [2:0] f3, input logic f7, input logic z,
                             input int rst_at);
        step_e s[$];
        bit    r;
        steps_for(op, s);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        for (int i = 0; i < s.size(); i++) begin
            r = (i == rst_at);
            reset = r;
            exp_q.push_back(model(s[i], op, f3, f7, z, r));
            tag_q.push_back($sformatf("%s c%0d", name, i + 1));
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (r) break;
        end
    endtask

    logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

    initial begin
        logic [6:0] rop;
        int         ra;
        reset = 1'b1;
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        @(posedge clk);
        #1;
        // Held in reset: FETCH outputs with write enables suppressed.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(SFetch, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1));
            tag_q.push_back($sformatf("reset c%0d", i));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        run_instr("beq_z1",  7'b1100011, 3'b000, 1'b0, 1'b1, -1);
        run_instr("beq_z0",  7'b1100011, 3'b000, 1'b0, 1'b0, -1);
        run_instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, -1);
        run_instr("addi",    7'b0010011, 3'b000, 1'b1, 1'b0, -1);
        run_instr("jalr",    7'b1100111, 3'b000, 1'b0, 1'b0, -1);
        run_instr("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0, -1);
        run_instr("sw_rst",  7'b0100011, 3'b010, 1'b0, 1'b0, 3);
        run_instr("post_rst_lui", 7'b0110111, 3'b000, 1'b0, 1'b0, -1);
        run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, -1);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 8) == 8) rop = 7'($urandom);
            else rop = ops[$urandom_range(0, 7)];
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr($sformatf("rnd%0d", n), rop, 3'($urandom), 1'($urandom),
                      1'($urandom), ra);
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and reset: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-002 The block SHALL have the following inputs: op input 7 (Instruction[6:0]); funct3 input 3 (Instruction[14:12]); funct7b5 input 1 (Instruction[30]); Zero input 1 (ALU zero flag).
REQ-003 The block SHALL have the following outputs: PCWrite output 1; AdrSrc output 1 (0 PC, 1 Result); MemWrite output 1; IRWrite output 1; RegWrite output 1.
REQ-004 The block SHALL have the following select outputs: ResultSrc output 2 (00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt); ALUSrcA output 2 (00 PC, 01 OldPC, 10 RD1); ALUSrcB output 2 (00 RD2, 01 ImmExt, 10 const 4).
REQ-005 The block SHALL have the following encoded outputs: ALUControl output 3 (000 add, 001 sub, 010 and, 011 or, 101 slt); ImmSrc output 3 (immediate generator select); Illegal output 1 (unsupported-opcode pulse).

Function
REQ-006 The block SHALL be a Moore FSM with the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, JALR, JALRLINK and LUI; the state register SHALL update on the rising edge of clk.
REQ-007 Transitions from FETCH: FETCH->DECODE.
REQ-008 Transitions from DECODE, by op: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BEQ; 1101111->JAL; 1100111->JALR; 0110111->LUI; any other op->FETCH.
REQ-009 Transitions from MEMADR: op 0000011->MEMREAD, otherwise->MEMWRITE.
REQ-010 Further transitions: MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL/JALRLINK->ALUWB; JALR->JALRLINK; MEMWB/MEMWRITE/ALUWB/BEQ/LUI->FETCH.
REQ-011 Every output not listed for a state SHALL be 0 in that state.
REQ-012 FETCH outputs: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCUpdate=1.
REQ-013 DECODE outputs: ALUSrcA=01, ALUSrcB=01, add (ALUOut=OldPC+imm).
REQ-014 MEMADR outputs: ALUSrcA=10, ALUSrcB=01, add.
REQ-015 MEMREAD outputs: ResultSrc=00, AdrSrc=1.
REQ-016 MEMWRITE outputs: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-017 MEMWB outputs: ResultSrc=01, RegWrite=1.
REQ-018 EXECUTER outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=funct.
REQ-019 EXECUTEI outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
REQ-020 ALUWB outputs: ResultSrc=00, RegWrite=1.
REQ-021 BEQ outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1.
REQ-022 JAL outputs: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1.
REQ-023 JALR outputs: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCUpdate=1.
REQ-024 JALRLINK outputs: ALUSrcA=01, ALUSrcB=10, add.
REQ-025 LUI outputs: ResultSrc=11, RegWrite=1.
REQ-026 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally within the same cycle.
REQ-027 The ALU decoder for ALUOp=funct SHALL map funct3 000 to sub when op[5]=1 and funct7b5=1, else to add; 010->slt; 110->or; 111->and; any other funct3->add.
REQ-028 ImmSrc SHALL be decoded combinationally from op in every state: 0000011/0010011/1100111->000; 0100011->001; 1100011->010; 1101111->011; 0110111->100; any other op->000.
REQ-029 Illegal SHALL be 1 only in DECODE when op is unsupported, giving a one-cycle pulse.
REQ-030 Instruction latency SHALL be: lw 5 cycles; sw, R, I-ALU and jal 4 cycles; jalr 5 cycles; beq and lui 3 cycles; illegal 2 cycles.

Reset
REQ-031 While reset=1, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0 combinationally.
REQ-032 Reset SHALL be honoured in any state, including mid-instruction, and SHALL place the FSM in FETCH at the next rising edge of clk.
REQ-033 After reset is released, the first cycle SHALL present the FETCH outputs.

Verification
REQ-034 The bench SHALL cover lw (op 0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; ImmSrc=000; RegWrite=1 with ResultSrc=01 only in cycle 5.
REQ-035 The bench SHALL cover beq (op 1100011, funct3 000) with Zero=1 then Zero=0: in cycle 3 ALUControl=001 and ImmSrc=010; PCWrite=1 for Zero=1 and PCWrite=0 for Zero=0.
REQ-036 The bench SHALL cover an R-type sub (op 0110011, funct3 000, funct7b5=1) followed by addi (op 0010011, funct3 000, funct7b5=1): EXECUTER gives ALUControl=001; EXECUTEI gives ALUControl=000.
REQ-037 The bench SHALL cover jalr (op 1100111): the state sequence JALR, JALRLINK, ALUWB; PCWrite=1 in JALR with ResultSrc=10; RegWrite=1 in ALUWB.
REQ-038 The bench SHALL cover an unsupported op 0000000: Illegal=1 for exactly one cycle in DECODE, then FETCH with no RegWrite or MemWrite asserted.
REQ-039 The bench SHALL cover reset asserted during MEMWRITE of sw (op 0100011): MemWrite=0 while reset=1; the state is FETCH after the next rising edge of clk.
